// File: rtl/csr_trap_seq_pkg.sv
// Shared encodings for the CSR / trap sequencer: opcodes, FSM states and
// machine-mode CSR addresses used by the sequencer and its neighbours.
package csr_trap_seq_pkg;

  localparam int unsigned OP_W       = 3;
  localparam int unsigned CSR_ADDR_W = 12;
  localparam int unsigned ZIMM_W     = 5;

  typedef enum logic [OP_W-1:0] {
    CSROP_NONE  = 3'd0,
    CSROP_RW    = 3'd1,
    CSROP_RS    = 3'd2,
    CSROP_RC    = 3'd3,
    CSROP_ECALL = 3'd4,
    CSROP_MRET  = 3'd5
  } csr_op_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CSR_RD    = 3'd1,
    ST_CSR_WR    = 3'd2,
    ST_TRAP_SAVE = 3'd3,
    ST_TRAP_JUMP = 3'd4,
    ST_MRET_JUMP = 3'd5,
    ST_REDIRECT  = 3'd6
  } state_e;

  localparam logic [CSR_ADDR_W-1:0] CSR_MSTATUS = 12'h300;
  localparam logic [CSR_ADDR_W-1:0] CSR_MTVEC   = 12'h305;
  localparam logic [CSR_ADDR_W-1:0] CSR_MEPC    = 12'h341;
  localparam logic [CSR_ADDR_W-1:0] CSR_MCAUSE  = 12'h342;

  localparam logic [3:0] MCAUSE_ECALL_M = 4'hb;

endpackage

// File: rtl/csr_rmw_alu.sv
// Read-modify-write value for CSRRW/CSRRS/CSRRC and the strobe choice,
// including suppression of set/clear writes whose source operand is zero.
module csr_rmw_alu
  import csr_trap_seq_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [OP_W-1:0] op_i,
  input  logic [XLEN-1:0] old_i,
  input  logic [XLEN-1:0] src_i,
  output logic [XLEN-1:0] new_o,
  output logic            wen_o,
  output logic            sen_o
);

  always_comb begin
    new_o = '0;
    wen_o = 1'b0;
    sen_o = 1'b0;
    case (op_i)
      CSROP_RW: begin
        new_o = src_i;
        wen_o = 1'b1;
      end
      CSROP_RS: begin
        new_o = old_i | src_i;
        sen_o = (src_i != '0);
      end
      CSROP_RC: begin
        new_o = old_i & ~src_i;
        sen_o = (src_i != '0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/csr_trap_seq.sv
// Sequencer between execute and the machine-mode CSR file: runs one CSR
// read-modify-write, ecall or mret at a time and issues the fetch redirect.
module csr_trap_seq
  import csr_trap_seq_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [OP_W-1:0]       in_op,
  input  logic                  in_use_imm,
  input  logic [ZIMM_W-1:0]     in_zimm,
  input  logic [XLEN-1:0]       in_rs1_rdata,
  input  logic [CSR_ADDR_W-1:0] in_csr_addr,
  input  logic [XLEN-1:0]       in_pc,
  output logic [CSR_ADDR_W-1:0] csr_read_addr,
  output logic [CSR_ADDR_W-1:0] csr_addr,
  output logic [XLEN-1:0]       rd_wdata,
  output logic                  csr_wen,
  output logic                  csr_sen,
  output logic                  ecall_write,
  output logic                  ecall_read,
  output logic [XLEN-1:0]       trap_pc,
  input  logic [XLEN-1:0]       csr_rdata,
  input  logic [XLEN-1:0]       mret_addr,
  output logic                  wb_valid,
  output logic [XLEN-1:0]       wb_data,
  output logic                  redirect_valid,
  output logic [XLEN-1:0]       redirect_target,
  input  logic                  redirect_ready,
  output logic                  busy
);

  state_e                  state_q, state_d;
  logic [OP_W-1:0]         op_q, op_d;
  logic [CSR_ADDR_W-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]         src_q, src_d;
  logic [XLEN-1:0]         pc_q, pc_d;
  logic [XLEN-1:0]         old_q, old_d;
  logic [XLEN-1:0]         target_q, target_d;

  logic [XLEN-1:0]         alu_new;
  logic                    alu_wen;
  logic                    alu_sen;

  csr_rmw_alu #(.XLEN(XLEN)) u_alu (
    .op_i  (op_q),
    .old_i (old_q),
    .src_i (src_q),
    .new_o (alu_new),
    .wen_o (alu_wen),
    .sen_o (alu_sen)
  );

  // Next-state and datapath register updates.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    addr_d   = addr_q;
    src_d    = src_q;
    pc_d     = pc_q;
    old_d    = old_q;
    target_d = target_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d   = in_op;
          addr_d = in_csr_addr;
          src_d  = in_use_imm ? XLEN'(in_zimm) : in_rs1_rdata;
          pc_d   = in_pc;
          case (in_op)
            CSROP_RW, CSROP_RS, CSROP_RC: state_d = ST_CSR_RD;
            CSROP_ECALL:                  state_d = ST_TRAP_SAVE;
            CSROP_MRET:                   state_d = ST_MRET_JUMP;
            default:                      state_d = ST_IDLE;
          endcase
        end
      end
      ST_CSR_RD: begin
        old_d   = csr_rdata;
        state_d = ST_CSR_WR;
      end
      ST_CSR_WR:    state_d = ST_IDLE;
      ST_TRAP_SAVE: state_d = ST_TRAP_JUMP;
      ST_TRAP_JUMP: begin
        // mtvec in direct mode: drop the two mode bits.
        target_d = csr_rdata & ~XLEN'(2'b11);
        state_d  = ST_REDIRECT;
      end
      ST_MRET_JUMP: begin
        target_d = mret_addr;
        state_d  = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        if (redirect_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      addr_q   <= '0;
      src_q    <= '0;
      pc_q     <= '0;
      old_q    <= '0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      src_q    <= src_d;
      pc_q     <= pc_d;
      old_q    <= old_d;
      target_q <= target_d;
    end
  end

  assign in_ready = (state_q == ST_IDLE);
  assign busy     = (state_q != ST_IDLE);

  // Output decode from the registered state; data buses are zero when idle.
  always_comb begin
    csr_read_addr   = (state_q == ST_IDLE) ? in_csr_addr : addr_q;
    csr_addr        = '0;
    rd_wdata        = '0;
    csr_wen         = 1'b0;
    csr_sen         = 1'b0;
    ecall_write     = 1'b0;
    ecall_read      = 1'b0;
    trap_pc         = '0;
    wb_valid        = 1'b0;
    wb_data         = '0;
    redirect_valid  = 1'b0;
    redirect_target = '0;
    case (state_q)
      ST_CSR_WR: begin
        csr_wen  = alu_wen;
        csr_sen  = alu_sen;
        wb_valid = 1'b1;
        wb_data  = old_q;
        if (alu_wen || alu_sen) begin
          csr_addr = addr_q;
          rd_wdata = alu_new;
        end
      end
      ST_TRAP_SAVE: begin
        ecall_write = 1'b1;
        trap_pc     = pc_q;
      end
      ST_TRAP_JUMP: ecall_read = 1'b1;
      ST_REDIRECT: begin
        redirect_valid  = 1'b1;
        redirect_target = target_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_csr_trap_seq.sv
// Bench for csr_trap_seq: a small CSR file model, table-driven CSR ops with a
// writeback scoreboard, and hand-written ecall/mret/reset/drop sequences.
module tb_csr_trap_seq;
  import csr_trap_seq_pkg::*;

  localparam int unsigned XLEN = 64;

  logic            clock;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      in_op;
  logic            in_use_imm;
  logic [4:0]      in_zimm;
  logic [63:0]     in_rs1_rdata;
  logic [11:0]     in_csr_addr;
  logic [63:0]     in_pc;
  logic [11:0]     csr_read_addr;
  logic [11:0]     csr_addr;
  logic [63:0]     rd_wdata;
  logic            csr_wen;
  logic            csr_sen;
  logic            ecall_write;
  logic            ecall_read;
  logic [63:0]     trap_pc;
  logic [63:0]     csr_rdata;
  logic [63:0]     mret_addr;
  logic            wb_valid;
  logic [63:0]     wb_data;
  logic            redirect_valid;
  logic [63:0]     redirect_target;
  logic            redirect_ready;
  logic            busy;

  csr_trap_seq #(.XLEN(XLEN)) dut (
    .clock           (clock),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_op           (in_op),
    .in_use_imm      (in_use_imm),
    .in_zimm         (in_zimm),
    .in_rs1_rdata    (in_rs1_rdata),
    .in_csr_addr     (in_csr_addr),
    .in_pc           (in_pc),
    .csr_read_addr   (csr_read_addr),
    .csr_addr        (csr_addr),
    .rd_wdata        (rd_wdata),
    .csr_wen         (csr_wen),
    .csr_sen         (csr_sen),
    .ecall_write     (ecall_write),
    .ecall_read      (ecall_read),
    .trap_pc         (trap_pc),
    .csr_rdata       (csr_rdata),
    .mret_addr       (mret_addr),
    .wb_valid        (wb_valid),
    .wb_data         (wb_data),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .redirect_ready  (redirect_ready),
    .busy            (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Environment model of the CSR file.
  logic [63:0] csr_mem [4096];
  initial begin
    for (int i = 0; i < 4096; i++) csr_mem[i] = '0;
    csr_mem[CSR_MSTATUS] = 64'h1800;
  end
  assign csr_rdata = ecall_read ? csr_mem[CSR_MTVEC] : csr_mem[csr_read_addr];
  assign mret_addr = csr_mem[CSR_MEPC];
  always @(posedge clock) begin
    if (csr_wen || csr_sen) csr_mem[csr_addr] <= rd_wdata;
    if (ecall_write) begin
      csr_mem[CSR_MEPC]   <= trap_pc;
      csr_mem[CSR_MCAUSE] <= 64'(MCAUSE_ECALL_M);
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] sb_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Writeback scoreboard and strobe exclusivity monitor.
  always @(negedge clock) begin
    if (!reset) begin
      check("strobe_onehot0",
            64'($onehot0({csr_wen, csr_sen, ecall_write, ecall_read})), 64'd1);
      if (wb_valid) begin
        if (sb_q.size() == 0) begin
          check("wb_unexpected", wb_data, 64'hdead_0000_dead_0000);
        end else begin
          check("wb_data", wb_data, sb_q.pop_front());
        end
      end
    end
  end

  typedef struct {
    logic [2:0]  op;
    logic        use_imm;
    logic [4:0]  zimm;
    logic [63:0] rs1;
    logic [11:0] addr;
    logic        exp_wen;
    logic        exp_sen;
    logic [63:0] exp_wdata;
    logic [63:0] exp_wb;
  } vec_t;

  vec_t vecs [8];

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (!in_ready) check("wait_ready_timeout", 64'(in_ready), 64'd1);
  endtask

  task automatic drive(input logic [2:0] op, input logic use_imm, input logic [4:0] zimm,
                       input logic [63:0] rs1, input logic [11:0] addr, input logic [63:0] pc);
    in_valid     = 1'b1;
    in_op        = op;
    in_use_imm   = use_imm;
    in_zimm      = zimm;
    in_rs1_rdata = rs1;
    in_csr_addr  = addr;
    in_pc        = pc;
  endtask

  task automatic idle_inputs();
    in_valid     = 1'b0;
    in_op        = '0;
    in_use_imm   = 1'b0;
    in_zimm      = '0;
    in_rs1_rdata = '0;
    in_csr_addr  = '0;
    in_pc        = '0;
  endtask

  // Called on a negedge with the DUT idle; returns on the first idle negedge after.
  task automatic run_csr(input vec_t v, input string tag);
    wait_ready();
    drive(v.op, v.use_imm, v.zimm, v.rs1, v.addr, 64'h0);
    sb_q.push_back(v.exp_wb);
    @(negedge clock);
    idle_inputs();
    check({tag, "_rd_busy"}, 64'(busy), 64'd1);
    check({tag, "_rd_raddr"}, 64'(csr_read_addr), 64'(v.addr));
    check({tag, "_rd_nostrobe"}, 64'({csr_wen, csr_sen, wb_valid}), 64'd0);
    @(negedge clock);
    check({tag, "_wr_wen"}, 64'(csr_wen), 64'(v.exp_wen));
    check({tag, "_wr_sen"}, 64'(csr_sen), 64'(v.exp_sen));
    check({tag, "_wr_wdata"}, rd_wdata, v.exp_wdata);
    check({tag, "_wr_addr"}, 64'(csr_addr),
          (v.exp_wen || v.exp_sen) ? 64'(v.addr) : 64'd0);
    check({tag, "_wr_wbvalid"}, 64'(wb_valid), 64'd1);
    @(negedge clock);
    check({tag, "_done_ready"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    vec_t v;
    int   rv_cnt;
    vecs[0] = '{CSROP_RW, 1'b0, 5'd0,  64'h8000_1000, CSR_MTVEC,   1'b1, 1'b0, 64'h8000_1000, 64'h0};
    vecs[1] = '{CSROP_RS, 1'b0, 5'd0,  64'h0,         CSR_MTVEC,   1'b0, 1'b0, 64'h0,         64'h8000_1000};
    vecs[2] = '{CSROP_RS, 1'b0, 5'd0,  64'h8,         CSR_MSTATUS, 1'b0, 1'b1, 64'h1808,      64'h1800};
    vecs[3] = '{CSROP_RC, 1'b1, 5'd8,  64'hffff,      CSR_MSTATUS, 1'b0, 1'b1, 64'h1800,      64'h1808};
    vecs[4] = '{CSROP_RC, 1'b1, 5'd0,  64'hffff,      CSR_MSTATUS, 1'b0, 1'b0, 64'h0,         64'h1800};
    vecs[5] = '{CSROP_RS, 1'b1, 5'h1f, 64'hf0f0,      12'h340,     1'b0, 1'b1, 64'h1f,        64'h0};
    vecs[6] = '{CSROP_RW, 1'b0, 5'd0,  64'h8000_1003, CSR_MTVEC,   1'b1, 1'b0, 64'h8000_1003, 64'h8000_1000};
    vecs[7] = '{CSROP_RC, 1'b0, 5'd0,  64'hffff_ffff_ffff_fff0, 12'h340, 1'b0, 1'b1, 64'hf, 64'h1f};

    idle_inputs();
    redirect_ready = 1'b1;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_redirect", 64'(redirect_valid), 64'd0);
    check("rst_wb", 64'(wb_valid), 64'd0);
    reset = 1'b0;
    @(negedge clock);
    check("post_rst_ready", 64'(in_ready), 64'd1);
    check("idle_raddr_passthru", 64'(csr_read_addr), 64'h0);

    for (int i = 0; i < 8; i++) run_csr(vecs[i], $sformatf("vec%0d", i));
    check("mstatus_final", csr_mem[CSR_MSTATUS], 64'h1800);

    // ECALL: save, mtvec fetch, redirect to aligned mtvec.
    wait_ready();
    drive(CSROP_ECALL, 1'b0, 5'd0, 64'h0, 12'h0, 64'h8000_0100);
    @(negedge clock);
    idle_inputs();
    check("ecall_save_strobe", 64'(ecall_write), 64'd1);
    check("ecall_save_pc", trap_pc, 64'h8000_0100);
    check("ecall_save_ready", 64'(in_ready), 64'd0);
    @(negedge clock);
    check("ecall_jump_read", 64'(ecall_read), 64'd1);
    check("ecall_jump_nowrite", 64'(ecall_write), 64'd0);
    check("ecall_jump_trappc0", trap_pc, 64'h0);
    @(negedge clock);
    check("ecall_redir_valid", 64'(redirect_valid), 64'd1);
    check("ecall_redir_target", redirect_target, 64'h8000_1000);
    @(negedge clock);
    check("ecall_done_valid", 64'(redirect_valid), 64'd0);
    check("ecall_mepc", csr_mem[CSR_MEPC], 64'h8000_0100);
    check("ecall_mcause", csr_mem[CSR_MCAUSE], 64'hb);

    // Move mepc forward, then MRET with fetch stalling three cycles.
    v = '{CSROP_RW, 1'b0, 5'd0, 64'h8000_0104, CSR_MEPC, 1'b1, 1'b0, 64'h8000_0104, 64'h8000_0100};
    run_csr(v, "mepc_wr");
    redirect_ready = 1'b0;
    drive(CSROP_MRET, 1'b0, 5'd0, 64'h0, 12'h0, 64'h0);
    @(negedge clock);
    idle_inputs();
    check("mret_jump_valid", 64'(redirect_valid), 64'd0);
    check("mret_jump_ready", 64'(in_ready), 64'd0);
    rv_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      if (redirect_valid) rv_cnt++;
      check("mret_hold_target", redirect_target, 64'h8000_0104);
      check("mret_hold_ready", 64'(in_ready), 64'd0);
      if (k == 3) redirect_ready = 1'b1;
    end
    check("mret_valid_cycles", 64'(rv_cnt), 64'd4);
    @(negedge clock);
    check("mret_done_valid", 64'(redirect_valid), 64'd0);
    check("mret_done_ready", 64'(in_ready), 64'd1);

    // Reset while in TRAP_JUMP abandons the ecall.
    drive(CSROP_ECALL, 1'b0, 5'd0, 64'h0, 12'h0, 64'h8000_0200);
    @(negedge clock);
    idle_inputs();
    @(negedge clock);
    check("rstmid_in_jump", 64'(ecall_read), 64'd1);
    reset = 1'b1;
    #1;
    check("rstmid_busy", 64'(busy), 64'd0);
    check("rstmid_strobe", 64'(ecall_read), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    rv_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      if (redirect_valid || busy) rv_cnt++;
    end
    check("rstmid_no_redirect", 64'(rv_cnt), 64'd0);
    check("rstmid_ready", 64'(in_ready), 64'd1);
    v = '{CSROP_RW, 1'b0, 5'd0, 64'h55, 12'h340, 1'b1, 1'b0, 64'h55, 64'hf};
    run_csr(v, "post_rst_rw");

    // Unknown opcode is consumed and dropped; next op accepted right after.
    drive(3'd0, 1'b0, 5'd0, 64'h1234, 12'h340, 64'h0);
    @(negedge clock);
    idle_inputs();
    check("drop_ready", 64'(in_ready), 64'd1);
    check("drop_nostrobe", 64'({csr_wen, csr_sen, ecall_write, ecall_read, wb_valid}), 64'd0);
    v = '{CSROP_RS, 1'b0, 5'd0, 64'h0, 12'h340, 1'b0, 1'b0, 64'h0, 64'h55};
    run_csr(v, "after_drop");
    drive(3'd7, 1'b0, 5'd0, 64'h0, 12'h0, 64'h0);
    @(negedge clock);
    idle_inputs();
    check("drop7_busy", 64'(busy), 64'd0);
    repeat (2) @(negedge clock);

    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
